// File: rtl/inst_fetcher_pkg.sv
// rtl/inst_fetcher_pkg.sv - shared types, opcode fields and helpers for the fetch front end
package inst_fetcher_pkg;

    typedef logic [31:0] word_tp;
    typedef logic [31:0] addr_tp;
    typedef logic [7:0]  byte_tp;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int OPC_LO = 0;
    localparam int OPC_HI = 6;
    localparam int RD_LO  = 7;
    localparam int RD_HI  = 11;
    localparam logic [6:0] OPC_JAL = 7'h6f;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PUSH  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        addr_tp pc;
        word_tp inst;
    } entry_t;

    function automatic addr_tp j_imm(input word_tp w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - memory port, redirect and decode-side handshake bundle
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic   mem_gnt;
    logic   mem_req;
    addr_tp mem_addr;
    byte_tp mem_din;
    logic   flush;
    addr_tp flush_pc;
    logic   inst_valid;
    word_tp inst;
    addr_tp inst_pc;
    logic   inst_ready;

    modport master (
        input  mem_gnt, mem_din, flush, flush_pc, inst_ready,
        output mem_req, mem_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output mem_gnt, mem_din, flush, flush_pc, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/inst_fetcher_inst_queue.sv
// rtl/inst_fetcher_inst_queue.sv - circular FIFO of {pc, inst} entries with push/pop/clear
module inst_queue #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [63:0]      push_data_i,
    input  logic             pop_i,
    output logic [63:0]      head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (pop_i)  head_d = head_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i && !clear_i) mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - byte-serial RV32I fetch into a word FIFO; FETCH_JAL_PREDICT_EN enables JAL redirect
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter addr_tp RESET_PC    = 32'h0,
    parameter int     QUEUE_DEPTH = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    inst_fetcher_if.master bus
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    fetch_state_e state_q, state_d;
    addr_tp       pc_q, pc_d;
    word_tp       word_q, word_d;
    logic [2:0]   iss_q, iss_d;
    logic [1:0]   cap_q, cap_d;
    logic         pend_q, pend_d;

    logic             issue, push, pop, clear;
    logic [CNT_W-1:0] q_count, cnt_after;
    entry_t           head;
    addr_tp           pred_pc;

`ifdef FETCH_JAL_PREDICT_EN
    assign pred_pc = (word_q[OPC_HI:OPC_LO] == OPC_JAL) ? pc_q + j_imm(word_q) : pc_q + 32'd4;
`else
    assign pred_pc = pc_q + 32'd4;
`endif

    assign pop       = rdy_in & ~bus.flush & bus.inst_valid & bus.inst_ready;
    assign cnt_after = q_count + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        word_d  = word_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        pend_d  = pend_q;
        issue   = FALSE;
        push    = FALSE;
        clear   = FALSE;
        if (rdy_in) begin
            if (bus.flush) begin
                // Killing pend_q here discards the byte of the aborted fetch.
                clear   = TRUE;
                pc_d    = bus.flush_pc & ~32'h3;
                state_d = ST_FETCH;
                iss_d   = '0;
                cap_d   = '0;
                pend_d  = FALSE;
                word_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (q_count < DEPTH_C) state_d = ST_FETCH;
                    end
                    ST_FETCH: begin
                        pend_d = FALSE;
                        if (iss_q != 3'd4) begin
                            issue = TRUE;
                            if (bus.mem_gnt) begin
                                iss_d  = iss_q + 3'd1;
                                pend_d = TRUE;
                            end
                        end
                        if (pend_q) begin
                            word_d[{cap_q, 3'b000} +: 8] = bus.mem_din;
                            cap_d = cap_q + 2'd1;
                            if (cap_q == 2'd3) state_d = ST_PUSH;
                        end
                    end
                    ST_PUSH: begin
                        push    = TRUE;
                        pc_d    = pred_pc;
                        iss_d   = '0;
                        cap_d   = '0;
                        state_d = (cnt_after < DEPTH_C) ? ST_FETCH : ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            word_q  <= '0;
            iss_q   <= '0;
            cap_q   <= '0;
            pend_q  <= FALSE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            pend_q  <= pend_d;
        end
    end

    inst_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .clear_i     (clear),
        .push_i      (push),
        .push_data_i ({pc_q, word_q}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (q_count)
    );

    assign bus.mem_req    = issue;
    assign bus.mem_addr   = (state_q == ST_FETCH) ? pc_q + {29'b0, iss_q} : '0;
    assign bus.inst_valid = (q_count != '0);
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - randomized scoreboard bench for inst_fetcher against a program-order model
module tb_inst_fetcher;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    inst_fetcher_if bus ();

    inst_fetcher #(
        .RESET_PC    (32'h0),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] JAL_NEXT = 32'h30;
`else
    localparam logic [31:0] JAL_NEXT = 32'h24;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          errors = 0;
    int          checks = 0;
    int          popped = 0;
    int          cyc = 0;

    int          gnt_mode = 0;
    int          ready_mode = 0;
    bit          rdy_rand = 0;
    bit          flush_now = 0;
    logic [31:0] flush_pc_v = '0;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    bit          prev_hold = 0;
    logic [31:0] prev_addr = '0;

    function automatic logic [7:0] mem_val(input logic [31:0] a);
        logic [7:0] b;
        case (a)
            32'h0:  return 8'h13;
            32'h1:  return 8'h05;
            32'h2:  return 8'h10;
            32'h3:  return 8'h00;
            32'h20: return 8'h6f;
            32'h21: return 8'h00;
            32'h22: return 8'h00;
            32'h23: return 8'h01;
            default: begin
                b = (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5a;
                if (a[1:0] == 2'b00 && b[6:0] == 7'h6f) b = b ^ 8'h01;
                return b;
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {mem_val(pc + 3), mem_val(pc + 2), mem_val(pc + 1), mem_val(pc)};
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w);
`ifdef FETCH_JAL_PREDICT_EN
        int imm;
        if (w[6:0] == 7'h6f) begin
            imm = (int'(w[31]) << 20) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
            if (w[31]) imm = imm - (1 << 21);
            return pc + imm;
        end
`endif
        return pc + 32'd4;
    endfunction

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 40) begin
            e.pc = model_pc;
            e.w  = word_at(model_pc);
            exp_q.push_back(e);
            model_pc = model_next(e.pc, e.w);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every accepted head is compared with the model's next program-order word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            #2;
            if (!rst_in && rdy_in && !bus.flush && bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", bus.inst_pc, e.pc);
                    check("inst", bus.inst, e.w);
                    popped++;
                    refill();
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_in);
        bus.mem_din = pend ? mem_val(pend_addr) : 8'($urandom);
        case (gnt_mode)
            0:       bus.mem_gnt = 1'b1;
            1:       bus.mem_gnt = ~bus.mem_gnt;
            default: bus.mem_gnt = 1'($urandom_range(0, 1));
        endcase
        if (ready_mode == 2) bus.inst_ready = ($urandom_range(0, 3) == 0);
        else                 bus.inst_ready = (ready_mode == 1);
        rdy_in = (rdy_rand && !pend) ? ($urandom_range(0, 7) != 0) : 1'b1;
        bus.flush    = flush_now;
        bus.flush_pc = flush_pc_v;
        if (flush_now && rdy_in) begin
            exp_q.delete();
            model_pc = flush_pc_v & ~32'h3;
            refill();
        end
        #1;
        cyc++;
        if (!rdy_in) check("req_frozen", {31'b0, bus.mem_req}, 32'd0);
        if (rdy_in && !bus.flush && prev_hold) begin
            check("hold_req", {31'b0, bus.mem_req}, 32'd1);
            check("hold_addr", bus.mem_addr, prev_addr);
        end
        if (rdy_in) begin
            prev_hold = bus.mem_req && !bus.mem_gnt && !bus.flush;
            prev_addr = bus.mem_addr;
        end
        pend      = rdy_in && bus.mem_req && bus.mem_gnt;
        pend_addr = bus.mem_addr;
        flush_now = 0;
    endtask

    initial begin
        int  first;
        bit  found;
        bit  seen23;

        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        bus.mem_gnt    = 1'b0;
        bus.mem_din    = 8'h0;
        bus.flush      = 1'b0;
        bus.flush_pc   = '0;
        bus.inst_ready = 1'b0;
        #12;
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        @(negedge clk_in);
        rst_in   = 1'b0;
        model_pc = 32'h0;
        refill();

        // First word latency and FIFO fill with the decoder stalled.
        gnt_mode   = 0;
        ready_mode = 0;
        first      = -1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (first < 0 && bus.mem_req) first = cyc;
            if (first >= 0 && cyc <= first + 3) begin
                check("lat_req", {31'b0, bus.mem_req}, 32'd1);
                check("lat_addr", bus.mem_addr, 32'(cyc - first));
            end
            if (first >= 0 && cyc == first + 5) check("lat_not_yet", {31'b0, bus.inst_valid}, 32'd0);
            if (first >= 0 && cyc == first + 6) begin
                check("lat_valid", {31'b0, bus.inst_valid}, 32'd1);
                check("lat_inst", bus.inst, 32'h00100513);
                check("lat_pc", bus.inst_pc, 32'h0);
            end
        end
        if (first < 0) check("first_issue_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_req", {31'b0, bus.mem_req}, 32'd0);
            check("full_valid", {31'b0, bus.inst_valid}, 32'd1);
        end
        ready_mode = 1;
        step();
        ready_mode = 0;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            step();
            if (bus.mem_req) begin
                found = 1;
                check("refetch_addr", bus.mem_addr, 32'h10);
            end
        end
        if (!found) check("refetch_timeout", 32'd0, 32'd1);

        // Alternating grant.
        ready_mode = 1;
        gnt_mode   = 1;
        repeat (80) step();

        // Flush after byte 1 of a fetch has been granted.
        gnt_mode   = 0;
        ready_mode = 2;
        found      = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (pend && pend_addr[1:0] == 2'b01) found = 1;
        end
        if (!found) check("byte1_timeout", 32'd0, 32'd1);
        flush_now  = 1;
        flush_pc_v = 32'h103;
        step();
        step();
        check("flush_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("flush_req", {31'b0, bus.mem_req}, 32'd1);
        check("flush_addr", bus.mem_addr, 32'h100);
        repeat (60) step();

        // Random grant, random decoder stalls and global enable drops.
        gnt_mode   = 2;
        rdy_rand   = 1;
        repeat (400) step();
        rdy_rand   = 0;

        // Steady streaming through many pointer wraps.
        gnt_mode   = 0;
        ready_mode = 1;
        repeat (200) step();

        // JAL at 0x20.
        flush_now  = 1;
        flush_pc_v = 32'h20;
        step();
        seen23 = 0;
        found  = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (seen23 && bus.mem_req) begin
                found = 1;
                check("jal_next_addr", bus.mem_addr, JAL_NEXT);
            end
            if (pend && pend_addr == 32'h23) seen23 = 1;
        end
        if (!found) check("jal_timeout", 32'd0, 32'd1);
        repeat (40) step();

        check("words_consumed", {31'b0, popped >= 60}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front end that produces 32-bit RV32I instruction words for the decoder.
- Reads memory one byte per cycle through the shared 8-bit memory port, assembles little-endian words, and buffers them with their PC in a small FIFO.
- Sits between the memory arbiter and the decode stage; the ROB/branch unit redirects it on mispredict.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- QUEUE_DEPTH, 4, instruction FIFO entries; power of 2, at least 2.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global enable; 0 freezes all state.
- mem_gnt  input  1  arbiter grants the memory port to this block this cycle.
- mem_req  output  1  byte read request.
- mem_addr  output  32  byte address of the request.
- mem_din  input  8  read data; valid the cycle after a granted request.
- flush  input  1  redirect; drop all buffered and in-flight work.
- flush_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0).
- inst_valid  output  1  FIFO head valid.
- inst  output  32  head instruction word.
- inst_pc  output  32  head instruction PC.
- inst_ready  input  1  decoder consumes head when inst_valid is 1.

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, state IDLE, mem_req=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, byte counters=0.
- rdy_in=0: no register changes, mem_req forced 0, an arriving mem_din is ignored. The bench never drops rdy_in while a byte is outstanding.
- FSM states:
  - IDLE: go to FETCH when FIFO count < QUEUE_DEPTH and flush=0.
  - FETCH: issue index k=0..3 with mem_req=1, mem_addr=pc+k. k advances only on cycles with mem_gnt=1. An ungranted cycle holds the same address.
  - Byte k is captured from mem_din the cycle after its granted issue into word bits [8k+7:8k]. After byte 3 is captured the state is PUSH.
  - PUSH: write {word, pc} to the FIFO tail, then pc += 4. Go to FETCH if count after this cycle's push/pop < QUEUE_DEPTH, else IDLE.
- Only one word is in flight at a time, so a PUSH always has a free slot.
- Latency with continuous grant: issues on t..t+3, bytes captured t+1..t+4, PUSH at t+5, word visible at inst_valid on t+6. Next issue is on t+6.
- FIFO: circular with head/tail pointers and a count of width log2(QUEUE_DEPTH)+1.
  - inst_valid = (count != 0); inst/inst_pc are the head entry.
  - Pop on inst_valid & inst_ready.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo QUEUE_DEPTH.
- flush (with rdy_in=1) has priority over all other events that cycle:
  - FIFO emptied, pop ignored, push suppressed, counters cleared.
  - pc=flush_pc & ~3, state FETCH; issue starts the next cycle.
  - A byte returning the cycle after flush belongs to the killed fetch and is discarded.
- PC arithmetic is 32-bit and wraps 32'hFFFFFFFC -> 0.

Optional Feature:
- Macro: FETCH_JAL_PREDICT_EN.
- When defined, in PUSH, if word[6:0] == 7'h6f (JAL), next pc = pc + J-imm, where J-imm is sign-extended {w[31], w[19:12], w[20], w[30:21], 0}.
- When undefined, next pc is always pc+4.
- A flush still overrides the prediction.

Decomposition:
- Shared utils header: WORD_TP, ADDR_TP, BYTE_TP, TRUE/FALSE, OPC_JAL 7'h6f, and the opcode/field bit-range macros already used by decode.
- One sub-module, inst_queue: parameterised circular FIFO with push/pop/clear, storing 64-bit {pc, inst} entries.

Test Plan:
- Reset, then mem_gnt=1 constantly; memory bytes at 0..3 = 13,05,10,00 -> addresses 0,1,2,3 on consecutive cycles; six cycles after the first issue inst_valid=1, inst=32'h00100513, inst_pc=0.
- inst_ready=0, QUEUE_DEPTH=4 -> after four words (pc 0,4,8,C) mem_req=0 and state IDLE. One pop -> fetch of pc 0x10 begins the next cycle.
- mem_gnt toggles 1,0,1,0,... -> mem_addr holds during ungranted cycles, the assembled word is still correct, and no byte is duplicated or skipped.
- flush with flush_pc=32'h103 issued mid-fetch (after byte 1) -> inst_valid=0 next cycle, the next issue address is 0x100, and the stale byte is not used.
- Simultaneous PUSH and pop with count=3 -> count stays 3, order is preserved, and pointers wrap correctly across 20 words.
- FETCH_JAL_PREDICT_EN: word 32'h0100006f at pc 0x20 -> next issue address 0x30. Without the macro the next issue address is 0x24.
